// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO that feeds a uart_tx one frame at a time
module uart_tx_feeder #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              osc_clk,
   input  logic              i_Rst_n,
   input  logic              i_Wr_DV,
   input  logic [7:0]        i_Wr_Byte,
   output logic              o_Full,
   output logic              o_Empty,
   output logic [ADDR_W:0]   o_Count,
   output logic              o_Overflow,
   output logic              o_Tx_DV,
   output logic [7:0]        o_Tx_Byte,
   input  logic              i_Tx_Active,
   input  logic              i_Tx_Done
);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_ACTIVE, WAIT_DONE} state_t;

   state_t              state, state_nxt;
   logic [7:0]          mem [DEPTH];
   logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
   logic [ADDR_W:0]     count_nxt;
   logic                avail, wr_ok, pop;

   assign wr_ok     = i_Wr_DV & ~o_Full;
   assign count_nxt = o_Count + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(pop);

   // next state, pop decision and launch strobe; avail delays the first pop so a byte sits one cycle before launch
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      o_Tx_DV   = 1'b0;
      case (state)
         IDLE: if (avail && !o_Empty && !i_Tx_Active) begin
            pop       = 1'b1;
            state_nxt = LAUNCH;
         end
         LAUNCH: begin
            o_Tx_DV   = 1'b1;
            state_nxt = WAIT_ACTIVE;
         end
         WAIT_ACTIVE: state_nxt = i_Tx_Done ? IDLE : (i_Tx_Active ? WAIT_DONE : WAIT_ACTIVE);
         WAIT_DONE:   state_nxt = i_Tx_Done ? IDLE : WAIT_DONE;
         default:     state_nxt = IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge osc_clk or negedge i_Rst_n) begin
      if (!i_Rst_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // FIFO storage, not reset
   always_ff @(posedge osc_clk) begin
      if (wr_ok) mem[wr_ptr] <= i_Wr_Byte;
   end

   // pointers, occupancy flags, sticky overflow and the held transmit byte
   always_ff @(posedge osc_clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         o_Count    <= '0;
         o_Empty    <= 1'b1;
         o_Full     <= 1'b0;
         o_Overflow <= 1'b0;
         o_Tx_Byte  <= 8'h00;
         avail      <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr    <= rd_ptr + 1'b1;
            o_Tx_Byte <= mem[rd_ptr];
         end
         if (i_Wr_DV && o_Full) o_Overflow <= 1'b1;
         o_Count <= count_nxt;
         o_Empty <= (count_nxt == '0);
         o_Full  <= (count_nxt == (ADDR_W+1)'(DEPTH));
         avail   <= ~o_Empty;
      end
   end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: scoreboard bench for uart_tx_feeder with a behavioral uart_tx
module tb_uart_tx_feeder;

   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;
   localparam int CPB    = 4;
   localparam int FRAME  = 10 * CPB;

   logic              osc_clk = 1'b0;
   logic              i_Rst_n;
   logic              i_Wr_DV;
   logic [7:0]        i_Wr_Byte;
   logic              o_Full, o_Empty, o_Overflow, o_Tx_DV;
   logic [ADDR_W:0]   o_Count;
   logic [7:0]        o_Tx_Byte;
   logic              i_Tx_Active, i_Tx_Done;
   logic              busy, hold;
   int                bit_cnt;
   int                pass_cnt = 0, total_cnt = 0, n_sent = 0;
   logic [7:0]        q [$];

   uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .osc_clk(osc_clk), .i_Rst_n(i_Rst_n), .i_Wr_DV(i_Wr_DV), .i_Wr_Byte(i_Wr_Byte),
      .o_Full(o_Full), .o_Empty(o_Empty), .o_Count(o_Count), .o_Overflow(o_Overflow),
      .o_Tx_DV(o_Tx_DV), .o_Tx_Byte(o_Tx_Byte), .i_Tx_Active(i_Tx_Active), .i_Tx_Done(i_Tx_Done)
   );

   always #5 osc_clk = ~osc_clk;

   assign i_Tx_Active = busy | hold;

   // behavioral uart_tx: busy for one frame after a start pulse, then a one-cycle done
   always @(posedge osc_clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         busy <= 1'b0;
         i_Tx_Done <= 1'b0;
         bit_cnt <= 0;
      end else begin
         i_Tx_Done <= 1'b0;
         if (!busy) begin
            if (o_Tx_DV) begin
               busy <= 1'b1;
               bit_cnt <= 0;
            end
         end else if (bit_cnt == FRAME - 1) begin
            busy <= 1'b0;
            i_Tx_Done <= 1'b1;
         end else bit_cnt <= bit_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // scoreboard: every launch must carry the oldest accepted byte
   always @(negedge osc_clk) begin
      if (i_Rst_n && o_Tx_DV) begin
         n_sent++;
         if (q.size() == 0) check("spurious_dv", 32'd1, 32'd0);
         else check("tx_byte", 32'(o_Tx_Byte), 32'(q.pop_front()));
      end
   end

   task automatic put(input logic [7:0] b, input bit acc);
      i_Wr_DV = 1'b1;
      i_Wr_Byte = b;
      if (acc) q.push_back(b);
      @(negedge osc_clk);
      i_Wr_DV = 1'b0;
   endtask

   task automatic drain();
      int k = 0;
      do begin
         @(negedge osc_clk);
         k++;
      end while (!(o_Empty && !busy && !o_Tx_DV) && k < 2000);
      check("drain_done", 32'(k < 2000), 32'd1);
      check("queue_empty", 32'(q.size()), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int s, k;
      i_Rst_n = 1'b0;
      i_Wr_DV = 1'b0;
      i_Wr_Byte = 8'h00;
      hold = 1'b0;
      repeat (3) @(negedge osc_clk);
      check("rst_count", 32'(o_Count), 32'd0);
      check("rst_empty", 32'(o_Empty), 32'd1);
      check("rst_full", 32'(o_Full), 32'd0);
      check("rst_ovf", 32'(o_Overflow), 32'd0);
      check("rst_dv", 32'(o_Tx_DV), 32'd0);
      check("rst_byte", 32'(o_Tx_Byte), 32'h00);
      i_Rst_n = 1'b1;
      @(negedge osc_clk);

      put(8'h30, 1'b1);
      @(negedge osc_clk);
      check("latency_n1", 32'(o_Tx_DV), 32'd0);
      @(negedge osc_clk);
      check("latency_n2", 32'(o_Tx_DV), 32'd1);
      check("single_byte", 32'(o_Tx_Byte), 32'h30);
      drain();
      check("single_sent", 32'(n_sent), 32'd1);
      check("single_empty", 32'(o_Empty), 32'd1);

      hold = 1'b1;
      for (int i = 0; i < 16; i++) put(8'h41 + 8'(i), 1'b1);
      check("burst_full", 32'(o_Full), 32'd1);
      check("burst_count", 32'(o_Count), 32'd16);
      check("burst_not_empty", 32'(o_Empty), 32'd0);
      put(8'hAA, 1'b0);
      check("ovf_count", 32'(o_Count), 32'd16);
      check("ovf_flag", 32'(o_Overflow), 32'd1);
      hold = 1'b0;
      drain();
      check("burst_count_zero", 32'(o_Count), 32'd0);
      check("ovf_sticky", 32'(o_Overflow), 32'd1);
      check("burst_sent", 32'(n_sent), 32'd17);

      hold = 1'b1;
      put(8'h60, 1'b1);
      put(8'h61, 1'b1);
      put(8'h62, 1'b1);
      @(negedge osc_clk);
      check("sim_count_before", 32'(o_Count), 32'd3);
      hold = 1'b0;
      i_Wr_DV = 1'b1;
      i_Wr_Byte = 8'h63;
      q.push_back(8'h63);
      @(negedge osc_clk);
      i_Wr_DV = 1'b0;
      check("sim_count_after", 32'(o_Count), 32'd3);
      check("sim_launch", 32'(o_Tx_DV), 32'd1);
      drain();
      check("sim_sent", 32'(n_sent), 32'd21);

      for (int i = 0; i < 40; i++) begin
         put(8'h80 + 8'(i), 1'b1);
         repeat (FRAME + 6) @(negedge osc_clk);
      end
      drain();
      check("wrap_sent", 32'(n_sent), 32'd61);

      hold = 1'b1;
      for (int i = 0; i < 5; i++) put(8'hC0 + 8'(i), 1'b1);
      @(negedge osc_clk);
      hold = 1'b0;
      k = 0;
      while (!o_Tx_DV && k < 20) begin
         @(negedge osc_clk);
         k++;
      end
      check("mid_dv_seen", 32'(o_Tx_DV), 32'd1);
      #2 i_Rst_n = 1'b0;
      #1;
      check("async_dv", 32'(o_Tx_DV), 32'd0);
      check("async_count", 32'(o_Count), 32'd0);
      check("async_empty", 32'(o_Empty), 32'd1);
      check("async_full", 32'(o_Full), 32'd0);
      check("async_ovf", 32'(o_Overflow), 32'd0);
      check("async_byte", 32'(o_Tx_Byte), 32'h00);
      q.delete();
      @(negedge osc_clk);
      i_Rst_n = 1'b1;
      s = n_sent;
      repeat (30) @(negedge osc_clk);
      check("no_dv_after_rst", 32'(n_sent - s), 32'd0);
      put(8'h5A, 1'b1);
      drain();
      check("post_rst_sent", 32'(n_sent - s), 32'd1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/uart_tx_feeder.md
UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO depth in bytes, power of two, minimum 2.
REQ-002 SHALL have parameter ADDR_W, default 4, log2(DEPTH).
REQ-003 SHALL have port osc_clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_Wr_DV  input  1  write strobe, one byte per high cycle.
REQ-006 SHALL have port i_Wr_Byte  input  8  byte to enqueue.
REQ-007 SHALL have port o_Full  output  1  FIFO holds DEPTH bytes.
REQ-008 SHALL have port o_Empty  output  1  FIFO holds 0 bytes.
REQ-009 SHALL have port o_Count  output  ADDR_W+1  bytes currently stored, 0..DEPTH.
REQ-010 SHALL have port o_Overflow  output  1  sticky flag, write attempted while full.
REQ-011 SHALL have port o_Tx_DV  output  1  start pulse to uart_tx i_Tx_DV.
REQ-012 SHALL have port o_Tx_Byte  output  8  byte to uart_tx i_Tx_Byte.
REQ-013 SHALL have port i_Tx_Active  input  1  from uart_tx o_Tx_Active.
REQ-014 SHALL have port i_Tx_Done  input  1  from uart_tx o_Tx_Done, one-cycle pulse.

Function
REQ-015 SHALL implement a DEPTH x 8 circular FIFO with ADDR_W-bit read/write pointers wrapping DEPTH-1 -> 0.
REQ-016 SHALL accept a write on an edge where i_Wr_DV=1 and o_Full=0; store i_Wr_Byte at the write pointer and advance it.
REQ-017 SHALL ignore a write while o_Full=1, even if a pop occurs on the same edge, and set o_Overflow=1; o_Overflow clears only on reset.
REQ-018 SHALL update o_Count as +1 on write only, -1 on pop only, unchanged on simultaneous write and pop.
REQ-019 SHALL drive o_Full, o_Empty and o_Count from registers, consistent with o_Count on every cycle.
REQ-020 SHALL use FSM states IDLE, LAUNCH, WAIT_ACTIVE, WAIT_DONE.
REQ-021 In IDLE, when o_Empty=0 and i_Tx_Active=0, the block SHALL pop the head byte into o_Tx_Byte, set o_Tx_DV=1 for the next cycle, and enter LAUNCH.
REQ-022 LAUNCH SHALL last exactly one cycle, then o_Tx_DV=0 and the FSM enters WAIT_ACTIVE.
REQ-023 WAIT_ACTIVE SHALL go to WAIT_DONE when i_Tx_Active=1, and SHALL go directly to IDLE if i_Tx_Done=1.
REQ-024 WAIT_DONE SHALL return to IDLE on the cycle after i_Tx_Done=1.
REQ-025 o_Tx_DV SHALL be high for exactly one cycle per popped byte, and never in any state other than LAUNCH.
REQ-026 o_Tx_Byte SHALL hold its value from the pop until the next pop.
REQ-027 Latency: a write accepted on edge N into an empty FIFO with the FSM in IDLE SHALL produce o_Tx_DV=1 during the cycle after edge N+2.
REQ-028 Bytes SHALL be transmitted in write order, with no loss or duplication absent overflow.
REQ-029 A write and a pop on the same edge with 0 < count < DEPTH SHALL both succeed.

Reset
REQ-030 While i_Rst_n=0 the block SHALL hold: pointers 0, o_Count=0, o_Empty=1, o_Full=0, o_Overflow=0, o_Tx_DV=0, o_Tx_Byte=8'h00, FSM in IDLE.
REQ-031 Reset asserted mid-transmission SHALL discard all stored bytes and deassert o_Tx_DV immediately, without waiting for a clock edge.
REQ-032 FIFO storage contents need not be reset.

Verification
REQ-033 Single byte: write 8'h30 with uart_tx at CLKS_PER_BIT=217 -> exactly one o_Tx_DV pulse with o_Tx_Byte=8'h30, serial frame 0x30 observed, o_Empty=1 afterwards.
REQ-034 Burst: write 8'h41..8'h50 (16 bytes) on consecutive cycles -> o_Full=1, o_Count=16; 16 frames sent in order; o_Count returns to 0.
REQ-035 Overflow: fill to 16, then write 8'hAA -> o_Overflow=1, 8'hAA never transmitted, o_Count stays 16 on that edge.
REQ-036 Wrap-around: 40 bytes written at a rate of one per frame time -> all 40 received in order across pointer wrap.
REQ-037 Reset mid-frame: i_Rst_n low while 5 bytes are queued -> all outputs at reset values asynchronously; after release, no o_Tx_DV until a new write.
REQ-038 Simultaneous events: write coinciding with the pop edge at count=3 -> o_Count stays 3, all bytes delivered.
